// File: rtl/uart_packet_parser_if.sv
// uart_packet_parser_if
// Groups the parser's byte-stream input, operand output, echo output and
// error reporting into one bundle.
//   slave  : the parser side (takes bytes, produces operands/echo/errors)
//   master : the environment side (UART RX, ALU, TX)
// Signals:
//   data_i/valid_i/ready_o            received byte stream with backpressure
//   op_data_o/op_opcode_o/op_first_o/
//   op_last_o/op_valid_o/op_ready_i   assembled operand stream to the ALU
//   echo_data_o/echo_valid_o/
//   echo_ready_i                      ECHO payload pass-through to TX
//   err_o/err_code_o                  error pulse and sticky error code
interface uart_packet_parser_if #(
  parameter int WIDTH_P = 32
);
  logic [7:0]         data_i;
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH_P-1:0] op_data_o;
  logic [7:0]         op_opcode_o;
  logic               op_first_o;
  logic               op_last_o;
  logic               op_valid_o;
  logic               op_ready_i;
  logic [7:0]         echo_data_o;
  logic               echo_valid_o;
  logic               echo_ready_i;
  logic               err_o;
  logic [1:0]         err_code_o;

  modport slave (
    input  data_i, valid_i, op_ready_i, echo_ready_i,
    output ready_o, op_data_o, op_opcode_o, op_first_o, op_last_o,
           op_valid_o, echo_data_o, echo_valid_o, err_o, err_code_o
  );

  modport master (
    output data_i, valid_i, op_ready_i, echo_ready_i,
    input  ready_o, op_data_o, op_opcode_o, op_first_o, op_last_o,
           op_valid_o, echo_data_o, echo_valid_o, err_o, err_code_o
  );
endinterface

// File: rtl/uart_packet_parser.sv
// uart_packet_parser
// Parses framed request packets (opcode, reserved, 16-bit LSB-first total
// length, payload) from a byte stream. ALU packets (A0/A1/A2) are assembled
// into WIDTH_P-bit little-endian operands; ECHO packets (EC) are passed
// through to the TX side with zero latency. Bad opcodes, bad lengths and
// inter-byte timeouts are reported on err_o/err_code_o.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    uart_packet_parser_if.slave (byte in, operand out, echo out, errors)
module uart_packet_parser #(
  parameter int WIDTH_P        = 32,
  parameter int MAX_OPERANDS_P = 8,
  parameter int TIMEOUT_P      = 100000
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_packet_parser_if.slave bus
);

  localparam int BYTES = WIDTH_P / 8;
  localparam int TW    = $clog2(TIMEOUT_P + 1);

  localparam logic [7:0] OPC_ECHO = 8'hEC;
  localparam logic [7:0] OPC_ADD  = 8'hA0;
  localparam logic [7:0] OPC_MUL  = 8'hA1;
  localparam logic [7:0] OPC_DIV  = 8'hA2;

  localparam logic [1:0] ERR_OPCODE  = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_LENGTH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RESERVED,
    S_LEN_LSB,
    S_LEN_MSB,
    S_OPERAND,
    S_HOLD,
    S_ECHO,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [7:0]      len_lsb_q, len_lsb_d;
  logic [15:0]     rem_q, rem_d;          // payload bytes still to pass/drain
  logic [15:0]     num_ops_q, num_ops_d;  // operands in current ALU packet
  logic [15:0]     op_idx_q, op_idx_d;    // index of operand being built/held
  logic [3:0]      bidx_q, bidx_d;        // byte lane within current operand
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            ready;
  logic            accept;
  logic            timer_runs;
  logic            tmo_hit;
  logic [15:0]     length_full;
  logic [15:0]     payload;
  logic [15:0]     n_ops;
  logic            alu_fits;
  logic [WIDTH_P-1:0] operand_w;

  function automatic logic is_alu(input logic [7:0] b);
    return (b == OPC_ADD) || (b == OPC_MUL) || (b == OPC_DIV);
  endfunction

  // Backpressure: stall while an operand is held, follow TX inside ECHO.
  always_comb begin
    ready = 1'b1;
    if (state_q == S_HOLD) begin
      ready = 1'b0;
    end else if (state_q == S_ECHO) begin
      ready = bus.echo_ready_i;
    end
  end

  assign accept     = bus.valid_i && ready;
  assign timer_runs = (state_q != S_OPCODE) && (state_q != S_HOLD);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit    = timer_runs && !accept && (tmo_q == TW'(TIMEOUT_P - 1));

  // Length checks use the MSB byte currently on the bus.
  assign length_full = {bus.data_i, len_lsb_q};
  assign payload     = length_full - 16'd4;
  assign n_ops       = payload / 16'(BYTES);
  assign alu_fits    = ((payload % 16'(BYTES)) == 16'd0) &&
                       (n_ops >= 16'd2) && (n_ops <= 16'(MAX_OPERANDS_P));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OPCODE;
      opcode_q   <= '0;
      len_lsb_q  <= '0;
      rem_q      <= '0;
      num_ops_q  <= '0;
      op_idx_q   <= '0;
      bidx_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_lsb_q  <= len_lsb_d;
      rem_q      <= rem_d;
      num_ops_q  <= num_ops_d;
      op_idx_q   <= op_idx_d;
      bidx_q     <= bidx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_lsb_d  = len_lsb_q;
    rem_d      = rem_q;
    num_ops_d  = num_ops_q;
    op_idx_d   = op_idx_q;
    bidx_d     = bidx_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (!timer_runs || accept) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (tmo_hit) begin
      state_d    = S_OPCODE;
      op_idx_d   = '0;
      bidx_d     = '0;
      tmo_d      = '0;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      case (state_q)
        S_OPCODE: begin
          if (accept) begin
            if (is_alu(bus.data_i) || (bus.data_i == OPC_ECHO)) begin
              opcode_d = bus.data_i;
              state_d  = S_RESERVED;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_OPCODE;
            end
          end
        end
        S_RESERVED: begin
          if (accept) state_d = S_LEN_LSB;
        end
        S_LEN_LSB: begin
          if (accept) begin
            len_lsb_d = bus.data_i;
            state_d   = S_LEN_MSB;
          end
        end
        S_LEN_MSB: begin
          if (accept) begin
            if (length_full < 16'd4) begin
              err_d      = 1'b1;
              err_code_d = ERR_SHORT;
              state_d    = S_OPCODE;
            end else if (opcode_q == OPC_ECHO) begin
              rem_d   = payload;
              state_d = (payload == 16'd0) ? S_OPCODE : S_ECHO;
            end else if (alu_fits) begin
              num_ops_d = n_ops;
              op_idx_d  = '0;
              bidx_d    = '0;
              state_d   = S_OPERAND;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_LENGTH;
              rem_d      = payload;
              state_d    = (payload == 16'd0) ? S_OPCODE : S_DRAIN;
            end
          end
        end
        S_OPERAND: begin
          if (accept) begin
            if (bidx_q == 4'(BYTES - 1)) begin
              bidx_d  = '0;
              state_d = S_HOLD;
            end else begin
              bidx_d = bidx_q + 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (bus.op_ready_i) begin
            if (op_idx_q == num_ops_q - 16'd1) begin
              op_idx_d = '0;
              state_d  = S_OPCODE;
            end else begin
              op_idx_d = op_idx_q + 16'd1;
              state_d  = S_OPERAND;
            end
          end
        end
        S_ECHO, S_DRAIN: begin
          if (accept) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = S_OPCODE;
          end
        end
        default: state_d = S_OPCODE;
      endcase
    end
  end

  // One register per byte lane; a lane loads when its byte is accepted.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] byte_q;
      logic       we;
      assign we = (state_q == S_OPERAND) && accept && (bidx_q == 4'(gi));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_q <= '0;
        end else if (we) begin
          byte_q <= bus.data_i;
        end
      end
      assign operand_w[8*gi +: 8] = byte_q;
    end
  endgenerate

  assign bus.ready_o      = ready;
  assign bus.op_valid_o   = (state_q == S_HOLD);
  assign bus.op_data_o    = operand_w;
  assign bus.op_opcode_o  = opcode_q;
  assign bus.op_first_o   = (state_q == S_HOLD) && (op_idx_q == 16'd0);
  assign bus.op_last_o    = (state_q == S_HOLD) && (op_idx_q == num_ops_q - 16'd1);
  assign bus.echo_valid_o = (state_q == S_ECHO) && bus.valid_i;
  assign bus.echo_data_o  = bus.data_i;
  assign bus.err_o        = err_q;
  assign bus.err_code_o   = err_code_q;

endmodule

// File: doc/uart_packet_parser.md
# uart_packet_parser

Parametrised byte-stream packet parser sitting between the UART receiver and the ALU. It accepts framed request packets (opcode, reserved, 16-bit length, payload) and handles them by type:
- ALU opcodes: payload is assembled into WIDTH_P-bit little-endian operands, presented on a valid/ready operand port with first/last markers.
- ECHO: payload bytes are forwarded unchanged to the TX path.

It adds backpressure, length validation, an inter-byte timeout and error reporting.

## Interface
Parameters:
- WIDTH_P, 32: operand width in bits; multiple of 8, range 8..64. BYTES = WIDTH_P/8.
- MAX_OPERANDS_P, 8: maximum operands per ALU packet.
- TIMEOUT_P, 100000: idle cycles allowed between bytes inside a packet.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- data_i  in  8  received byte.
- valid_i  in  1  data_i valid.
- ready_o  out  1  parser accepts data_i this cycle. A byte is accepted when valid_i && ready_o.
- op_data_o  out  WIDTH_P  assembled operand.
- op_opcode_o  out  8  opcode of the current packet.
- op_first_o / op_last_o  out  1  first / last operand of the packet.
- op_valid_o  out  1  operand valid.
- op_ready_i  in  1  ALU accepts the operand.
- echo_data_o  out  8  echoed byte.
- echo_valid_o  out  1  echo byte valid.
- echo_ready_i  in  1  TX accepts the echo byte.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  code of the last error; held until the next error.

## Operation
- Opcodes: ECHO=0xEC, ADD=0xA0, MUL=0xA1, DIV=0xA2.
- Length field: 16 bits, LSB first, counts the total packet bytes including the 4 header bytes.
- States:
  - OPCODE: a valid opcode is latched, go to RESERVED. Any other byte is dropped, pulses err (code 0) and stays in OPCODE.
  - RESERVED: accept one byte (value ignored), go to LEN_LSB.
  - LEN_LSB: accept the byte into length[7:0], go to LEN_MSB.
  - LEN_MSB: accept the byte into length[15:8], then validate (see below).
  - OPERAND: each accepted byte goes to bits [8k+7:8k], k = 0..BYTES-1. After byte BYTES-1, go to HOLD.
  - HOLD: op_valid_o=1 and ready_o=0. On op_ready_i, go to OPERAND, or to OPCODE if it was the last operand.
  - ECHO: forward payload bytes until length-4 bytes are transferred, then go to OPCODE.
  - DRAIN: accept and discard length-4 bytes, then go to OPCODE.
- Validation at LEN_MSB acceptance, with P = length-4:
  - length<4: err code 1, go to OPCODE.
  - ECHO with P=0: go to OPCODE.
  - ECHO with P>0: go to ECHO.
  - ALU opcode, P a multiple of BYTES and 2 <= P/BYTES <= MAX_OPERANDS_P: go to OPERAND.
  - Otherwise: err code 2, go to DRAIN (DRAIN also consumes the payload).
- ECHO state is pass-through: echo_valid_o=valid_i, echo_data_o=data_i, ready_o=echo_ready_i.
- ready_o=1 in every state except HOLD and ECHO.
- op_first_o=1 only on operand 0. op_last_o=1 only on operand P/BYTES-1.
- Byte and operand counters are 16 bits. The packet ends exactly at byte number length; no wrap is possible.
- Timeout: a counter clears on each accepted byte and increments every cycle in RESERVED, LEN_*, OPERAND, ECHO and DRAIN. It does not run in OPCODE or HOLD.
  - On reaching TIMEOUT_P: err code 3, discard the partial packet, go to OPCODE on the next cycle.
  - If a byte arrives on the same cycle the counter reaches TIMEOUT_P, the byte is accepted and the timeout is suppressed.
- err_o priority: only one error source is possible per state, so there are no simultaneous errors.

## Timing
- Reset (async assert, sync release):
  - State is OPCODE; all counters are 0.
  - Outputs: ready_o=1, op_valid_o=0, echo_valid_o=0, err_o=0, err_code_o=0, op_data_o=0, op_opcode_o=0, op_first_o=0, op_last_o=0.
- Reset mid-packet: the packet is abandoned with no error pulse.
- Each accepted byte advances state on the same clock edge.
- Operand latency: last operand byte accepted at edge N gives op_valid_o=1 from cycle N+1.
- op_data_o, op_opcode_o, op_first_o and op_last_o are stable while op_valid_o=1 and !op_ready_i.
- Throughput: BYTES+1 cycles minimum per operand, since HOLD costs at least one cycle.
- err_o asserts in the cycle after the offending acceptance or timeout and lasts exactly one cycle.
- ECHO pass-through has zero latency, with a combinational valid_i→echo_valid_o and echo_ready_i→ready_o path.

## Test plan
- ADD, WIDTH_P=32: bytes A0 00 0C 00 11 22 33 44 55 66 77 88 -> two operands:
  - 0x44332211 with first=1;
  - 0x88776655 with last=1;
  - op_opcode_o=A0, err_o never pulses.
- Backpressure: same packet with op_ready_i low for 5 cycles -> ready_o=0 and op_data_o stable throughout; byte 0x55 is accepted only after the handshake.
- ECHO: EC 00 07 00 61 62 63 with echo_ready_i toggling -> echo_data_o sequence 61,62,63 with no loss or duplication; returns to OPCODE.
- Length errors:
  - A1 00 02 00 -> err_code_o=1, back in OPCODE.
  - A2 00 07 00 + 3 bytes -> err_code_o=2; the 3 bytes are drained and the next packet parses correctly.
- Stray byte 0x5A in OPCODE -> err code 0; the following valid packet parses correctly.
- Timeout with TIMEOUT_P=16: stall after A0 00 -> err code 3 after exactly 16 idle cycles. A byte arriving on cycle 16 is accepted with no error. Asserting rst_n low mid-packet returns all outputs to their reset values immediately.
